// File: rtl/driver_cmd_receiver.sv
// driver_cmd_receiver: LED-driver-side responder for the SIN/SCLK/LAT/SOUT bus.
// The bus is oversampled on clk_hse. SCLK rising edges are counted while LAT is
// high, and the count is decoded when LAT falls. The block holds the
// function-control (FC) register and shifts it out on driver_sout for readback.
// Optional build macro DRV_CMD_RECEIVER_STATS_EN adds saturating event counters
// (stat_wrtgs, stat_latgs, stat_err).
module driver_cmd_receiver #(
  parameter int SR_WIDTH     = 48,
  parameter int MAX_GS_WORDS = 16
) (
  input  logic                clk_hse,
  input  logic                rst,
  input  logic                driver_sclk,
  input  logic                driver_lat,
  input  logic                driver_sin,
  output logic                driver_sout,
  output logic                cmd_valid,
  output logic [3:0]          cmd_code,
  output logic                cmd_error,
  output logic [SR_WIDTH-1:0] fc_reg,
  output logic                fc_unlocked,
  output logic [4:0]          gs_word_cnt,
  output logic [4:0]          latgs_words,
  output logic                latgs_pulse,
  output logic                line_reset_pulse,
  output logic                gs_overflow
`ifdef DRV_CMD_RECEIVER_STATS_EN
  ,
  output logic [15:0]         stat_wrtgs,
  output logic [15:0]         stat_latgs,
  output logic [7:0]          stat_err
`endif
);

  localparam logic [4:0] GS_MAX = 5'(MAX_GS_WORDS);

  logic                sclk_q;
  logic                lat_q;
  logic [SR_WIDTH-1:0] sr;
  logic [SR_WIDTH-1:0] sout_sr;
  logic [4:0]          lat_cnt;

  logic                sclk_rise;
  logic                lat_fall;
  logic [4:0]          cnt_next;
  logic [SR_WIDTH-1:0] sr_next;

  // Edge detect, plus the count and shift register as they will be after this
  // cycle, so that an SCLK edge in the same cycle as LAT falling is decoded.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sclk_rise = driver_sclk & ~sclk_q;
    lat_fall  = lat_q & ~driver_lat;
    cnt_next  = lat_cnt;
    sr_next   = sr;
    if (sclk_rise) begin
      sr_next = {sr[SR_WIDTH-2:0], driver_sin};
      if (lat_q && (lat_cnt != 5'd31)) cnt_next = lat_cnt + 5'd1;
    end
  end

  assign driver_sout = sout_sr[SR_WIDTH-1];

  // Bus sampling, shifting, command decode and command actions.
  always_ff @(posedge clk_hse or posedge rst) begin
    if (rst) begin
      sclk_q           <= 1'b0;
      lat_q            <= 1'b0;
      sr               <= '0;
      sout_sr          <= '0;
      lat_cnt          <= '0;
      cmd_valid        <= 1'b0;
      cmd_code         <= '0;
      cmd_error        <= 1'b0;
      fc_reg           <= '0;
      fc_unlocked      <= 1'b0;
      gs_word_cnt      <= '0;
      latgs_words      <= '0;
      latgs_pulse      <= 1'b0;
      line_reset_pulse <= 1'b0;
      gs_overflow      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge state.
      sclk_q           <= driver_sclk;
      lat_q            <= driver_lat;
      cmd_valid        <= 1'b0;
      cmd_error        <= 1'b0;
      latgs_pulse      <= 1'b0;
      line_reset_pulse <= 1'b0;

      if (sclk_rise) begin
        sr      <= sr_next;
        sout_sr <= {sout_sr[SR_WIDTH-2:0], 1'b0};
      end

      if (lat_fall) begin
        lat_cnt   <= '0;
        cmd_valid <= 1'b1;
        // Counts above 15 are illegal; only the low nibble is reported.
        cmd_code  <= cnt_next[3:0];
        case (cnt_next)
          5'd1: begin
            if (gs_word_cnt == GS_MAX) gs_overflow <= 1'b1;
            else                       gs_word_cnt <= gs_word_cnt + 5'd1;
          end
          5'd3: begin
            latgs_words <= gs_word_cnt + 5'd1;
            gs_word_cnt <= '0;
            latgs_pulse <= 1'b1;
          end
          5'd5: begin
            if (fc_unlocked) begin
              fc_reg      <= sr_next;
              fc_unlocked <= 1'b0;
            end else begin
              cmd_error <= 1'b1;
            end
          end
          5'd7: begin
            gs_word_cnt      <= '0;
            line_reset_pulse <= 1'b1;
          end
          // Load wins over the shift above when both land in one cycle.
          5'd11:   sout_sr     <= fc_reg;
          5'd15:   fc_unlocked <= 1'b1;
          default: cmd_error   <= 1'b1;
        endcase
      end else if (sclk_rise && lat_q) begin
        lat_cnt <= cnt_next;
      end
    end
  end

`ifdef DRV_CMD_RECEIVER_STATS_EN
  // Saturating event counters driven from the registered decode outputs.
  always_ff @(posedge clk_hse or posedge rst) begin
    if (rst) begin
      stat_wrtgs <= '0;
      stat_latgs <= '0;
      stat_err   <= '0;
    end else begin
      if (cmd_valid && !cmd_error && (cmd_code == 4'd1) && (stat_wrtgs != 16'hFFFF))
        stat_wrtgs <= stat_wrtgs + 16'd1;
      if (cmd_valid && !cmd_error && (cmd_code == 4'd3) && (stat_latgs != 16'hFFFF))
        stat_latgs <= stat_latgs + 16'd1;
      if (cmd_error && (stat_err != 8'hFF))
        stat_err <= stat_err + 8'd1;
    end
  end
`endif

endmodule

// File: doc/driver_cmd_receiver.md
Name: driver_cmd_receiver

Overview:
- Synthesizable LED-driver-side model of the SIN/SCLK/LAT/SOUT command interface.
- Oversamples the driver bus on the fast clock and counts SCLK rising edges while LAT is high.
- Decodes the LAT command (WRTGS/LATGS/WRTFC/LINERESET/READFC/FCWRTEN), holds the 48-bit FC register and drives SOUT for config readback.
- Used on-FPGA as a loopback target and in the bench as the responder to the driver controller.

Parameters:
- SR_WIDTH, 48, width of the common input shift register and of the FC register.
- MAX_GS_WORDS, 16, GS words allowed between two LATGS/LINERESET before overflow is flagged.

Ports:
- clk_hse  input  1  system clock; samples all bus inputs.
- rst  input  1  asynchronous, active-high reset.
- driver_sclk  input  1  driver SCLK; must be slower than clk_hse/2.
- driver_lat  input  1  driver LAT.
- driver_sin  input  1  driver SIN, one channel.
- driver_sout  output  1  config readback data.
- cmd_valid  output  1  one-cycle pulse when a command is decoded.
- cmd_code  output  4  last decoded SCLK-edge count (1, 3, 5, 7, 11, 15); held until the next command.
- cmd_error  output  1  one-cycle pulse on an illegal command.
- fc_reg  output  SR_WIDTH  current function-control register.
- fc_unlocked  output  1  set after FCWRTEN, cleared after WRTFC.
- gs_word_cnt  output  5  WRTGS words received since the last LATGS/LINERESET.
- latgs_words  output  5  GS word count captured at the last LATGS, including the LATGS word itself.
- latgs_pulse  output  1  one-cycle pulse on LATGS.
- line_reset_pulse  output  1  one-cycle pulse on LINERESET.
- gs_overflow  output  1  sticky; set when gs_word_cnt would exceed MAX_GS_WORDS.

Behaviour:
- Reset values:
  - All outputs 0; fc_reg = 0.
  - Internal shift register, lat_cnt and sout shift register = 0.
  - sclk_q and lat_q = 0.
- Edge detection: sclk_q and lat_q are registered copies of the inputs.
  - sclk_rise = driver_sclk & ~sclk_q.
  - lat_fall = lat_q & ~driver_lat.
- On sclk_rise:
  - sr <= {sr[SR_WIDTH-2:0], driver_sin}, MSB first.
  - If lat_q = 1, lat_cnt increments, saturating at 31.
  - The sout shift register shifts left by one.
- On lat_fall: lat_cnt is decoded. If sclk_rise occurs in the same cycle, that edge is counted before decoding.
- Decoded outputs are registered: cmd_valid and cmd_code appear 1 clk_hse cycle after the lat_fall cycle. lat_cnt is cleared in that cycle.
- Command actions:
  - 1 WRTGS: gs_word_cnt +1.
  - 3 LATGS: latgs_words <= gs_word_cnt+1, gs_word_cnt <= 0, latgs_pulse.
  - 5 WRTFC: if fc_unlocked, fc_reg <= sr and fc_unlocked <= 0; otherwise cmd_error and fc_reg is unchanged.
  - 7 LINERESET: gs_word_cnt <= 0, line_reset_pulse.
  - 11 READFC: sout shift register <= fc_reg.
  - 15 FCWRTEN: fc_unlocked <= 1.
- Illegal counts: 0, even values, 9, 13, and any count >15. Each raises cmd_error with cmd_valid, and no other state changes.
- WRTGS when gs_word_cnt = MAX_GS_WORDS: gs_overflow set (sticky until rst), counter holds.
- driver_sout:
  - Equals bit SR_WIDTH-1 of the sout shift register, combinational from the register.
  - The first bit is valid from the cycle after the READFC decode; the register shifts on each later sclk_rise.
  - Zeros shift in after 48 bits.
- LAT rising without any SCLK edge, then falling: count 0 → cmd_error.
- rst asserted mid-command:
  - All state returns to reset values immediately.
  - A LAT already high when rst deasserts is not counted as a rise; its edges count normally, and its fall decodes.

Optional Feature:
- DRV_CMD_RECEIVER_STATS_EN: adds outputs stat_wrtgs (16b), stat_latgs (16b) and stat_err (8b). These are saturating counters of decoded WRTGS, LATGS and cmd_error events, cleared by rst.
- Without the macro those ports and counters do not exist.

Test Plan:
- 15 SCLK edges with LAT high, LAT falls → cmd_valid, cmd_code=15, fc_unlocked=1.
- Then shift 48 bits 0xA5A5_1234_5678 with LAT high on the last 5 edges → cmd_code=5, fc_reg=0xA5A51234_5678, fc_unlocked=0.
- WRTFC (5 edges) with fc_unlocked=0 → cmd_error pulse, fc_reg unchanged.
- READFC (11 edges), then 48 SCLK edges → driver_sout reproduces fc_reg MSB first, then 0.
- 8×WRTGS then 1×LATGS → latgs_words=9, gs_word_cnt=0, latgs_pulse once; 17 WRTGS without LATGS → gs_overflow=1.
- LAT with 4 SCLK edges, and separately 0 edges → cmd_error each, no state change; rst mid-stream → all outputs 0.
